pipeline_hazard_ctrl: RTL

Central hazard and sequencing controller for the 5-stage core. It drives stall and flush enables for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and selects EX-stage operand forwarding. It also holds the pipeline while data memory is not ready and halts it on a memory timeout. It reads register addresses and control bits already carried by those pipeline registers and keeps saturating stall and flush counters for performance analysis.

---
 rtl/pipeline_hazard_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard and sequencing controller for the 5-stage core.
// It drives the stall/flush enables of the pipeline registers and the EX operand
// forwarding selects. It holds the pipeline while data memory is not ready and
// halts it on a memory timeout. Saturating stall and flush counters are kept.
// Optional feature macro: FWD_EN (operand forwarding; stall only on load-use).
// Without FWD_EN, any source match against EX/MEM/WB stalls and fwd is 00.
module pipeline_hazard_ctrl #(
    parameter int WAIT_TIMEOUT = 255,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic             WE3_e,
    input  logic             load_e,
    input  logic [1:0]       PCNext_select_e,
    input  logic [4:0]       rd_m,
    input  logic             WE3_m,
    input  logic [4:0]       rd_w,
    input  logic             WE3_w,
    input  logic             mem_req_m,
    input  logic             mem_ready,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_w,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic             mem_timeout,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_HALT     = 2'b10
    } state_t;

    localparam logic [1:0]       STEP_FORWARD = 2'b00;
    localparam logic [15:0]      TIMEOUT_C    = 16'(WAIT_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    state_t      state_r;
    logic [15:0] wait_cnt_r;
    logic        mem_wait_s;
    logic        redirect_s;
    logic        data_hazard_s;
    logic        redirect_act_s;

    // x0 never matches; a destination only matches when it is actually written
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst,
                                       input logic we);
        return (dst != 5'd0) && we && (src == dst);
    endfunction

    // MEM result wins over WB result; otherwise read the register file
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (reg_match(src, rd_m, WE3_m)) begin
            return 2'b10;
        end else if (reg_match(src, rd_w, WE3_w)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    assign mem_wait_s = mem_req_m && !mem_ready && (state_r != ST_HALT);
    assign redirect_s = (PCNext_select_e != STEP_FORWARD);

`ifdef FWD_EN
    // Data hazard: only a load in EX feeding an ID source cannot be forwarded
    always_comb begin
        data_hazard_s = load_e && (reg_match(rs1_d, rd_e, WE3_e) ||
                                   reg_match(rs2_d, rd_e, WE3_e));
    end

    // Operand forwarding selects, forced to register file while in reset
    always_comb begin
        fwd_a_e = 2'b00;
        fwd_b_e = 2'b00;
        if (reset) begin
            fwd_a_e = 2'b00;
            fwd_b_e = 2'b00;
        end else begin
            fwd_a_e = fwd_sel(rs1_e);
            fwd_b_e = fwd_sel(rs2_e);
        end
    end
`else
    logic unused_inputs_s;
    assign unused_inputs_s = ^{rs1_e, rs2_e, load_e};

    // Data hazard: no bypass anywhere, so any in-flight writer of an ID source stalls
    always_comb begin
        data_hazard_s = reg_match(rs1_d, rd_e, WE3_e) || reg_match(rs2_d, rd_e, WE3_e) ||
                        reg_match(rs1_d, rd_m, WE3_m) || reg_match(rs2_d, rd_m, WE3_m) ||
                        reg_match(rs1_d, rd_w, WE3_w) || reg_match(rs2_d, rd_w, WE3_w);
    end

    // Forwarding unused in this build: operands always come from the register file
    always_comb begin
        fwd_a_e = 2'b00;
        fwd_b_e = 2'b00;
    end
`endif

    // Prioritised stall/flush decode: halt, memory wait, redirect, data hazard
    always_comb begin
        stall_f        = 1'b0;
        stall_d        = 1'b0;
        stall_e        = 1'b0;
        stall_m        = 1'b0;
        flush_d        = 1'b0;
        flush_e        = 1'b0;
        flush_w        = 1'b0;
        redirect_act_s = 1'b0;
        if (reset) begin
            redirect_act_s = 1'b0;
        end else if (state_r == ST_HALT) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
        end else if (mem_wait_s) begin
            // MEM holds its access; WB receives a bubble
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (redirect_s) begin
            flush_d        = 1'b1;
            flush_e        = 1'b1;
            redirect_act_s = 1'b1;
        end else if (data_hazard_s) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end else begin
            redirect_act_s = 1'b0;
        end
    end

    // Sequencing FSM with wait timer and registered timeout/halt flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_RUN;
            wait_cnt_r  <= 16'd0;
            mem_timeout <= 1'b0;
            halted      <= 1'b0;
        end else begin
            mem_timeout <= 1'b0;
            case (state_r)
                ST_RUN: begin
                    if (mem_wait_s) begin
                        state_r    <= ST_MEM_WAIT;
                        wait_cnt_r <= 16'd1;
                    end else begin
                        wait_cnt_r <= 16'd0;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!mem_wait_s) begin
                        state_r    <= ST_RUN;
                        wait_cnt_r <= 16'd0;
                    end else if (wait_cnt_r == TIMEOUT_C) begin
                        state_r     <= ST_HALT;
                        mem_timeout <= 1'b1;
                        halted      <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 16'd1;
                    end
                end
                ST_HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    state_r    <= ST_RUN;
                    wait_cnt_r <= 16'd0;
                    halted     <= 1'b0;
                end
            endcase
        end
    end

    // Saturating performance counters for stall cycles and redirect flushes
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= {CNT_W{1'b0}};
            flush_cnt <= {CNT_W{1'b0}};
        end else begin
            if (stall_f && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end else begin
                stall_cnt <= stall_cnt;
            end
            if (redirect_act_s && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end else begin
                flush_cnt <= flush_cnt;
            end
        end
    end

endmodule
